// File: rtl/ws2812_frame_scheduler.sv
// Frame scheduler for the APA102-to-WS2812 bridge: detects SPI end-of-burst, commits the shadow
// frame, starts the transmitter, enforces the latch gap and optionally refreshes. Option: SCHED_GRB_REORDER_EN.
module ws2812_frame_scheduler #(
  parameter int unsigned LED_CNT        = 7,
  parameter int unsigned IDLE_CYCLES    = 1000,
  parameter int unsigned LATCH_CYCLES   = 3000,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic [24*LED_CNT-1:0] frame_in,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [24*LED_CNT-1:0] tx_data,
  output logic [7:0]            frame_count,
  output logic                  pending,
  output logic                  tx_err
);

  localparam int unsigned FrameW      = 24 * LED_CNT;
  localparam int unsigned BusyTimeout = 16;
  localparam bit          RefreshEn   = (REFRESH_CYCLES != 0);
  localparam int unsigned MaxIL  = (IDLE_CYCLES > LATCH_CYCLES) ? IDLE_CYCLES : LATCH_CYCLES;
  localparam int unsigned MaxILR = (MaxIL > REFRESH_CYCLES) ? MaxIL : REFRESH_CYCLES;
  localparam int unsigned CntMax = (MaxILR > BusyTimeout) ? MaxILR : BusyTimeout;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle, StQuiet, StCommit, StStart, StWaitBusy, StTx, StGap
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                sck_meta_q, sck_sync_q, sck_prev_q;
  logic                act_q, act_d;
  logic                tx_start_q, tx_start_d;
  logic [FrameW-1:0]   tx_data_q, tx_data_d;
  logic [FrameW-1:0]   commit_data;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                pending_q, pending_d;
  logic                tx_err_q, tx_err_d;
  logic                commit;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_meta_q    <= 1'b0;
      sck_sync_q    <= 1'b0;
      sck_prev_q    <= 1'b0;
      act_q         <= 1'b0;
      state_q       <= StIdle;
      cnt_q         <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_count_q <= 8'd0;
      pending_q     <= 1'b0;
      tx_err_q      <= 1'b0;
    end else begin
      sck_meta_q    <= sck;
      sck_sync_q    <= sck_meta_q;
      sck_prev_q    <= sck_sync_q;
      act_q         <= act_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      frame_count_q <= frame_count_d;
      pending_q     <= pending_d;
      tx_err_q      <= tx_err_d;
    end
  end

`ifdef SCHED_GRB_REORDER_EN
  // Each pixel {B,G,R} becomes {G,R,B}; chain order is preserved.
  always_comb begin
    commit_data = '0;
    for (int unsigned i = 0; i < LED_CNT; i++) begin
      commit_data[24*i +: 24] = {frame_in[24*i+8 +: 8], frame_in[24*i +: 8],
                                 frame_in[24*i+16 +: 8]};
    end
  end
`else
  assign commit_data = frame_in;
`endif

  always_comb begin
    act_d     = sck_sync_q ^ sck_prev_q;
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    pending_d = pending_q;
    tx_err_d  = tx_err_q;
    commit    = 1'b0;

    if (act_q && !(state_q inside {StIdle, StQuiet})) pending_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (!RefreshEn) cnt_d = '0;
        if (act_q) begin
          state_d = StQuiet;
        end else if (RefreshEn && (cnt_q == CntW'(REFRESH_CYCLES - 1))) begin
          state_d = StStart;
        end
      end
      StQuiet: begin
        // Counter reaches IDLE_CYCLES-1 on the edge that enters COMMIT.
        if (act_q) begin
          cnt_d = '0;
        end else if (cnt_q == CntW'(IDLE_CYCLES - 2)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        state_d = StStart;
      end
      StStart: state_d = StWaitBusy;
      StWaitBusy: begin
        // The START cycle counts toward the busy timeout.
        if (tx_busy) begin
          state_d = StTx;
        end else if (cnt_q == CntW'(BusyTimeout - 2)) begin
          tx_err_d = 1'b1;
          state_d  = StGap;
        end
      end
      StTx: if (!tx_busy) state_d = StGap;
      StGap: begin
        if (cnt_q == CntW'(LATCH_CYCLES - 1)) begin
          if (pending_q || act_q) begin
            state_d   = StQuiet;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = '0;

    tx_start_d    = (state_d == StStart);
    tx_data_d     = commit ? commit_data : tx_data_q;
    frame_count_d = commit ? frame_count_q + 8'd1 : frame_count_q;
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign frame_count = frame_count_q;
  assign pending     = pending_q;
  assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Directed bench for ws2812_frame_scheduler: burst commit, pending, timeout, reset, wrap, refresh.
module tb_ws2812_frame_scheduler;

  localparam int unsigned Idle    = 8;
  localparam int unsigned Latch   = 10;
  localparam int unsigned Refresh = 20;

`ifdef SCHED_GRB_REORDER_EN
  localparam logic [47:0] ExpF1 = {24'h00FF00, 24'h000000};
  localparam logic [47:0] ExpF2 = {24'h345612, 24'hCDEFAB};
`else
  localparam logic [47:0] ExpF1 = {24'h0000FF, 24'h000000};
  localparam logic [47:0] ExpF2 = {24'h123456, 24'hABCDEF};
`endif

  logic        clk = 1'b0;
  logic        reset, sck, tx_busy, sck_b, busy_b;
  logic [47:0] frame_in, frame_b;
  logic        tx_start, pending, tx_err, tx_start_b, pending_b, tx_err_b;
  logic [47:0] tx_data, tx_data_b;
  logic [7:0]  frame_count, frame_count_b;

  int n_cmp = 0;
  int n_bad = 0;
  int n, starts, lat_bad;

  always #5 clk = ~clk;

  ws2812_frame_scheduler #(
    .LED_CNT(2), .IDLE_CYCLES(Idle), .LATCH_CYCLES(Latch), .REFRESH_CYCLES(0)
  ) u_dut (
    .clk(clk), .reset(reset), .sck(sck), .frame_in(frame_in), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .frame_count(frame_count),
    .pending(pending), .tx_err(tx_err)
  );

  ws2812_frame_scheduler #(
    .LED_CNT(2), .IDLE_CYCLES(Idle), .LATCH_CYCLES(Latch), .REFRESH_CYCLES(Refresh)
  ) u_dut_refresh (
    .clk(clk), .reset(reset), .sck(sck_b), .frame_in(frame_b), .tx_busy(busy_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .frame_count(frame_count_b),
    .pending(pending_b), .tx_err(tx_err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int cnt);
    repeat (cnt) tick();
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input bit on_b, input int max_ticks, output int cnt);
    cnt = 0;
    while (((on_b ? tx_start_b : tx_start) == 1'b0) && cnt < max_ticks) begin
      tick();
      cnt++;
    end
  endtask

  task automatic finish_tx();
    tx_busy = 1'b1;
    tick_n(2);
    tx_busy = 1'b0;
    tick_n(Latch + 3);
  endtask

  initial begin
    reset = 1'b1; sck = 1'b0; tx_busy = 1'b0; frame_in = '0;
    sck_b = 1'b0; busy_b = 1'b0; frame_b = 48'hA5A5A5_5A5A5A;
    tick_n(3);
    check("rst_tx_start", 64'(tx_start), 64'(0));
    check("rst_tx_data", 64'(tx_data), 64'(0));
    check("rst_frame_count", 64'(frame_count), 64'(0));
    check("rst_pending", 64'(pending), 64'(0));
    check("rst_tx_err", 64'(tx_err), 64'(0));
    reset = 1'b0;
    tick_n(2);

    // 24-edge burst, then quiet
    frame_in = {24'h0000FF, 24'h000000};
    for (int i = 0; i < 24; i++) begin
      sck = ~sck;
      if (i != 23) tick_n(2);
    end
    wait_start(1'b0, 40, n);
    check("burst_latency", 64'(n), 64'(Idle + 4));
    check("burst_tx_data", 64'(tx_data), 64'(ExpF1));
    check("burst_frame_count", 64'(frame_count), 64'(1));
    tx_busy = 1'b1;
    tick();
    check("start_pulse_width", 64'(tx_start), 64'(0));

    // SCK activity while transmitting
    tick();
    sck = 1'b1; tick_n(2); sck = 1'b0; tick_n(4);
    check("pending_set_in_tx", 64'(pending), 64'(1));
    frame_in = {24'h123456, 24'hABCDEF};
    tick_n(3);
    check("tx_data_stable", 64'(tx_data), 64'(ExpF1));
    tx_busy = 1'b0;
    tick_n(Latch);
    check("pending_held_in_gap", 64'(pending), 64'(1));
    tick();
    check("pending_clear_quiet", 64'(pending), 64'(0));
    check("no_start_in_gap", 64'(tx_start), 64'(0));
    wait_start(1'b0, 40, n);
    check("pending_latency", 64'(n), 64'(Idle));
    check("pending_frame_count", 64'(frame_count), 64'(2));
    check("pending_tx_data", 64'(tx_data), 64'(ExpF2));

    // Dead transmitter
    check("err_clear_before", 64'(tx_err), 64'(0));
    n = 0;
    while (!tx_err && n < 40) begin
      tick();
      n++;
    end
    check("err_latency", 64'(n), 64'(16));
    starts = 0;
    repeat (60) begin
      tick();
      if (tx_start) starts++;
    end
    check("no_refresh_disabled", 64'(starts), 64'(0));
    check("err_sticky", 64'(tx_err), 64'(1));
    check("err_frame_count", 64'(frame_count), 64'(2));

    // Reset during TX
    frame_in = {24'h00FF00, 24'hFF0000};
    sck = 1'b1; tick_n(2); sck = 1'b0;
    wait_start(1'b0, 40, n);
    check("burst2_latency", 64'(n), 64'(Idle + 4));
    check("burst2_frame_count", 64'(frame_count), 64'(3));
    tx_busy = 1'b1;
    tick_n(2);
    sck = 1'b1; tick_n(2); sck = 1'b0; tick_n(4);
    check("pending_before_reset", 64'(pending), 64'(1));
    reset = 1'b1;
    tick();
    check("mid_rst_tx_start", 64'(tx_start), 64'(0));
    check("mid_rst_tx_data", 64'(tx_data), 64'(0));
    check("mid_rst_frame_count", 64'(frame_count), 64'(0));
    check("mid_rst_pending", 64'(pending), 64'(0));
    check("mid_rst_tx_err", 64'(tx_err), 64'(0));
    reset = 1'b0;
    tx_busy = 1'b0;
    starts = 0;
    repeat (40) begin
      tick();
      if (tx_start) starts++;
    end
    check("no_start_after_reset", 64'(starts), 64'(0));
    frame_in = {24'h0000FF, 24'h000000};
    sck = 1'b1; tick_n(2); sck = 1'b0;
    wait_start(1'b0, 40, n);
    check("post_rst_latency", 64'(n), 64'(Idle + 4));
    check("post_rst_frame_count", 64'(frame_count), 64'(1));
    finish_tx();

    // Wrap of frame_count
    lat_bad = 0;
    for (int k = 0; k < 254; k++) begin
      sck = ~sck;
      wait_start(1'b0, 40, n);
      if (n != Idle + 4) lat_bad++;
      finish_tx();
    end
    check("wrap_latencies", 64'(lat_bad), 64'(0));
    check("count_255", 64'(frame_count), 64'(255));
    sck = ~sck;
    wait_start(1'b0, 40, n);
    check("count_wrap_0", 64'(frame_count), 64'(0));
    finish_tx();
    check("wrap_tx_err", 64'(tx_err), 64'(0));

    // Periodic refresh on the second instance
    sck = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_start(1'b1, 60, n);
    check("refresh_first", 64'(n), 64'(Refresh));
    for (int p = 0; p < 2; p++) begin
      busy_b = 1'b1;
      tick_n(5);
      busy_b = 1'b0;
      wait_start(1'b1, 80, n);
      check("refresh_period", 64'(n + 5), 64'(Refresh + 5 + Latch + 1));
      check("refresh_tx_data", 64'(tx_data_b), 64'(0));
      check("refresh_frame_count", 64'(frame_count_b), 64'(0));
      check("refresh_tx_err", 64'(tx_err_b), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
